// File: rtl/alu_unit_pkg.sv
// Shared opcode encoding, widths and result bundle for the ALU issue/CDB slice.
// The optional RV32M multiplier is selected with the ALU_MUL_EN macro.
package alu_unit_pkg;

    localparam int XLEN = 32;
    localparam int TAGW = 4;
    localparam int OPW  = 6;

    // I-type ALU ops reuse the register-form codes; the RS substitutes the immediate into rs2.
    typedef enum logic [OPW-1:0] {
        OP_NOP    = 6'd0,
        OP_LUI    = 6'd1,
        OP_AUIPC  = 6'd2,
        OP_JAL    = 6'd3,
        OP_JALR   = 6'd4,
        OP_BEQ    = 6'd5,
        OP_BNE    = 6'd6,
        OP_BLT    = 6'd7,
        OP_BGE    = 6'd8,
        OP_BLTU   = 6'd9,
        OP_BGEU   = 6'd10,
        OP_ADD    = 6'd11,
        OP_SUB    = 6'd12,
        OP_SLL    = 6'd13,
        OP_SLT    = 6'd14,
        OP_SLTU   = 6'd15,
        OP_XOR    = 6'd16,
        OP_SRL    = 6'd17,
        OP_SRA    = 6'd18,
        OP_OR     = 6'd19,
        OP_AND    = 6'd20,
        OP_MUL    = 6'd21,
        OP_MULH   = 6'd22,
        OP_MULHSU = 6'd23,
        OP_MULHU  = 6'd24
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] ans;
        logic            jump;
        logic [XLEN-1:0] jump_pc;
    } alu_res_t;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [TAGW-1:0] tag;
    } issue_t;

    function automatic logic is_branch_op(input logic [OPW-1:0] op);
        return (op == OP_BEQ)  || (op == OP_BNE)  || (op == OP_BLT) ||
               (op == OP_BGE)  || (op == OP_BLTU) || (op == OP_BGEU);
    endfunction

    function automatic logic is_mul_op(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_unit_if.sv
// RS->ALU issue bundle plus the ALU CDB broadcast, with issuer and ALU views.
interface alu_unit_if;
    import alu_unit_pkg::*;

    logic            flag_alu;
    logic [OPW-1:0]  op_alu;
    logic [XLEN-1:0] rs1_alu;
    logic [XLEN-1:0] rs2_alu;
    logic [XLEN-1:0] imm_alu;
    logic [XLEN-1:0] pc_alu;
    logic [TAGW-1:0] rob_alu;

    logic            alu_ans_flag;
    logic [TAGW-1:0] alu_ans_reorder;
    logic [XLEN-1:0] alu_ans;
    logic            alu_jump;
    logic [XLEN-1:0] alu_jump_pc;

    modport master (
        output flag_alu, op_alu, rs1_alu, rs2_alu, imm_alu, pc_alu, rob_alu,
        input  alu_ans_flag, alu_ans_reorder, alu_ans, alu_jump, alu_jump_pc
    );

    modport slave (
        input  flag_alu, op_alu, rs1_alu, rs2_alu, imm_alu, pc_alu, rob_alu,
        output alu_ans_flag, alu_ans_reorder, alu_ans, alu_jump, alu_jump_pc
    );

endinterface

// File: rtl/alu_core.sv
// Pure combinational RV32I execute: opcode/operands/pc/imm -> result, taken flag, next PC.
// Multiply opcodes are not handled here and fall through as unknown (all zero).
module alu_core
    import alu_unit_pkg::*;
(
    input  logic [OPW-1:0]  op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] pc_i,
    output alu_res_t        res_o
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_tgt;
    logic            take;

    always_comb begin
        // NOTE: every output and temporary gets a default before the case so no path infers a latch.
        pc_plus4 = pc_i + XLEN'(4);
        br_tgt   = pc_i + imm_i;
        take     = 1'b0;
        res_o    = '0;

        case (op_i)
            OP_ADD:   res_o.ans = rs1_i + rs2_i;
            OP_SUB:   res_o.ans = rs1_i - rs2_i;
            OP_AND:   res_o.ans = rs1_i & rs2_i;
            OP_OR:    res_o.ans = rs1_i | rs2_i;
            OP_XOR:   res_o.ans = rs1_i ^ rs2_i;
            OP_SLT:   res_o.ans = {{(XLEN-1){1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
            OP_SLTU:  res_o.ans = {{(XLEN-1){1'b0}}, (rs1_i < rs2_i)};
            OP_SLL:   res_o.ans = rs1_i << rs2_i[4:0];
            OP_SRL:   res_o.ans = rs1_i >> rs2_i[4:0];
            OP_SRA:   res_o.ans = XLEN'($signed(rs1_i) >>> rs2_i[4:0]);
            OP_LUI:   res_o.ans = imm_i;
            OP_AUIPC: res_o.ans = br_tgt;
            OP_JAL: begin
                res_o.ans     = pc_plus4;
                res_o.jump    = 1'b1;
                res_o.jump_pc = br_tgt;
            end
            OP_JALR: begin
                res_o.ans     = pc_plus4;
                res_o.jump    = 1'b1;
                res_o.jump_pc = (rs1_i + imm_i) & ~XLEN'(1);
            end
            OP_BEQ:   take = (rs1_i == rs2_i);
            OP_BNE:   take = (rs1_i != rs2_i);
            OP_BLT:   take = ($signed(rs1_i) < $signed(rs2_i));
            OP_BGE:   take = ($signed(rs1_i) >= $signed(rs2_i));
            OP_BLTU:  take = (rs1_i < rs2_i);
            OP_BGEU:  take = (rs1_i >= rs2_i);
            default: ;
        endcase

        // Branches always report a next PC so the ROB can check the prediction either way.
        if (is_branch_op(op_i)) begin
            res_o.jump    = take;
            res_o.jump_pc = take ? br_tgt : pc_plus4;
        end
    end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: pipeline, rdy freeze / clr flush handling and the CDB output registers.
// ALU_MUL_EN adds RV32M multiply and makes every op take two cycles.
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      clr,
    alu_unit_if.slave bus
);

    issue_t          iss;

    logic            out_vld_q, out_vld_d;
    logic            flag_q, flag_d;
    logic [TAGW-1:0] tag_q, tag_d;
    alu_res_t        res_q, res_d;

    logic            src_vld;
    logic [TAGW-1:0] src_tag;
    alu_res_t        src_res;
    alu_res_t        core_res;

    assign iss = '{op: bus.op_alu, rs1: bus.rs1_alu, rs2: bus.rs2_alu,
                   imm: bus.imm_alu, pc: bus.pc_alu, tag: bus.rob_alu};

`ifdef ALU_MUL_EN
    logic               s1_vld_q, s1_vld_d;
    issue_t             s1_q, s1_d;
    logic [49:0]        pp_lo_q, pp_lo_d;
    logic [47:0]        pp_hi_q, pp_hi_d;

    logic               sign_a, sign_b;
    logic signed [32:0] mul_a, mul_b;
    logic signed [49:0] pp_lo;
    logic signed [47:0] pp_hi;
    logic [63:0]        prod;
    logic [XLEN-1:0]    mul_res;

    // Stage 1: 33x33 product split over the low 16 / high 17 bits of the multiplier.
    always_comb begin
        sign_a = (iss.op == OP_MULH) || (iss.op == OP_MULHSU);
        sign_b = (iss.op == OP_MULH);
        mul_a  = {sign_a & iss.rs1[XLEN-1], iss.rs1};
        mul_b  = {sign_b & iss.rs2[XLEN-1], iss.rs2};
        pp_lo  = 50'(mul_a) * 50'($signed({1'b0, mul_b[15:0]}));
        pp_hi  = 48'(mul_a) * 48'($signed(mul_b[32:16]));
    end

    // Stage 2: final sum; only the low 64 bits of the product are ever needed.
    always_comb begin
        prod    = {{14{pp_lo_q[49]}}, pp_lo_q} + {pp_hi_q, 16'b0};
        mul_res = (s1_q.op == OP_MUL) ? prod[31:0] : prod[63:32];
    end

    alu_core u_core (
        .op_i  (s1_q.op),
        .rs1_i (s1_q.rs1),
        .rs2_i (s1_q.rs2),
        .imm_i (s1_q.imm),
        .pc_i  (s1_q.pc),
        .res_o (core_res)
    );

    always_comb begin
        src_vld = s1_vld_q;
        src_tag = s1_q.tag;
        src_res = core_res;
        if (is_mul_op(s1_q.op)) begin
            src_res     = '0;
            src_res.ans = mul_res;
        end
    end
`else
    alu_core u_core (
        .op_i  (iss.op),
        .rs1_i (iss.rs1),
        .rs2_i (iss.rs2),
        .imm_i (iss.imm),
        .pc_i  (iss.pc),
        .res_o (core_res)
    );

    assign src_vld = bus.flag_alu;
    assign src_tag = iss.tag;
    assign src_res = core_res;
`endif

    // out_vld_q && !flag_q only arises after a freeze: the result was shown while consumers
    // were stalled, so the first enabled edge replays it and holds the rest of the pipe.
    always_comb begin
        out_vld_d = out_vld_q;
        flag_d    = flag_q;
        tag_d     = tag_q;
        res_d     = res_q;
`ifdef ALU_MUL_EN
        s1_vld_d  = s1_vld_q;
        s1_d      = s1_q;
        pp_lo_d   = pp_lo_q;
        pp_hi_d   = pp_hi_q;
`endif
        if (clr) begin
            out_vld_d = 1'b0;
            flag_d    = 1'b0;
`ifdef ALU_MUL_EN
            s1_vld_d  = 1'b0;
`endif
        end else if (!rdy) begin
            flag_d = 1'b0;
        end else if (out_vld_q && !flag_q) begin
            flag_d = 1'b1;
        end else begin
            out_vld_d = src_vld;
            flag_d    = src_vld;
            if (src_vld) begin
                tag_d = src_tag;
                res_d = src_res;
            end
`ifdef ALU_MUL_EN
            s1_vld_d = bus.flag_alu;
            if (bus.flag_alu) begin
                s1_d    = iss;
                pp_lo_d = pp_lo;
                pp_hi_d = pp_hi;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset too, because they drive the CDB directly and must read 0.
            out_vld_q <= 1'b0;
            flag_q    <= 1'b0;
            tag_q     <= '0;
            res_q     <= '0;
`ifdef ALU_MUL_EN
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            pp_lo_q   <= '0;
            pp_hi_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            out_vld_q <= out_vld_d;
            flag_q    <= flag_d;
            tag_q     <= tag_d;
            res_q     <= res_d;
`ifdef ALU_MUL_EN
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            pp_lo_q   <= pp_lo_d;
            pp_hi_q   <= pp_hi_d;
`endif
        end
    end

    assign bus.alu_ans_flag    = flag_q;
    assign bus.alu_ans_reorder = tag_q;
    assign bus.alu_ans         = res_q.ans;
    assign bus.alu_jump        = res_q.jump;
    assign bus.alu_jump_pc     = res_q.jump_pc;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit; latency follows the ALU_MUL_EN build option.
module tb_alu_unit;
    import alu_unit_pkg::*;

`ifdef ALU_MUL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst;
    logic rdy;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    alu_unit_if bus ();

    alu_unit dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_res(input string name, input logic [3:0] tag, input logic [31:0] ans,
                             input logic jump, input logic [31:0] jpc);
        check({name, ".flag"},    {31'b0, bus.alu_ans_flag},   32'd1);
        check({name, ".reorder"}, 32'(bus.alu_ans_reorder),    32'(tag));
        check({name, ".ans"},     bus.alu_ans,                 ans);
        check({name, ".jump"},    {31'b0, bus.alu_jump},       32'(jump));
        check({name, ".jump_pc"}, bus.alu_jump_pc,             jpc);
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        bus.flag_alu = 1'b1;
        bus.op_alu   = op;
        bus.rs1_alu  = a;
        bus.rs2_alu  = b;
        bus.imm_alu  = imm;
        bus.pc_alu   = pc;
        bus.rob_alu  = tag;
    endtask

    // Issue one op and return at the negedge where its result is on the CDB.
    task automatic exec(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        drive(op, a, b, imm, pc, tag);
        @(negedge clk);
        bus.flag_alu = 1'b0;
        repeat (LAT - 1) @(negedge clk);
    endtask

    int k;

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        drive(OP_NOP, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        bus.flag_alu = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.flag",    {31'b0, bus.alu_ans_flag}, 32'd0);
        check("rst.reorder", 32'(bus.alu_ans_reorder),  32'd0);
        check("rst.ans",     bus.alu_ans,               32'd0);
        check("rst.jump",    {31'b0, bus.alu_jump},     32'd0);
        check("rst.jump_pc", bus.alu_jump_pc,           32'd0);
        rst = 1'b0;
        @(negedge clk);

        // First op, single pulse, outputs hold afterwards
        exec(OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3);
        check_res("add", 4'd3, 32'd12, 1'b0, 32'd0);
        @(negedge clk);
        check("add.pulse_end", {31'b0, bus.alu_ans_flag}, 32'd0);
        check("add.hold_ans",  bus.alu_ans,               32'd12);

        // Arithmetic / logic / shifts
        exec(OP_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 4'd1);
        check_res("sub", 4'd1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        exec(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd2);
        check_res("sra", 4'd2, 32'hF800_0000, 1'b0, 32'd0);
        exec(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3);
        check_res("sltu", 4'd3, 32'd1, 1'b0, 32'd0);
        exec(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd4);
        check_res("slt", 4'd4, 32'd0, 1'b0, 32'd0);
        exec(OP_SRL, 32'h8000_0000, 32'h0000_0024, 32'd0, 32'd0, 4'd5);
        check_res("srl", 4'd5, 32'h0800_0000, 1'b0, 32'd0);
        exec(OP_SLL, 32'd1, 32'h0000_0021, 32'd0, 32'd0, 4'd6);
        check_res("sll", 4'd6, 32'd2, 1'b0, 32'd0);
        exec(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h10, 32'h500, 4'd7);
        check_res("and", 4'd7, 32'h0000_F000, 1'b0, 32'd0);
        exec(OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 4'd8);
        check_res("or", 4'd8, 32'h0000_FFF0, 1'b0, 32'd0);
        exec(OP_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 4'd9);
        check_res("xor", 4'd9, 32'h0000_0FF0, 1'b0, 32'd0);
        exec(OP_LUI, 32'd0, 32'd0, 32'h1234_5000, 32'h700, 4'd10);
        check_res("lui", 4'd10, 32'h1234_5000, 1'b0, 32'd0);
        exec(OP_AUIPC, 32'd0, 32'd0, 32'h0000_2000, 32'h0000_1000, 4'd11);
        check_res("auipc", 4'd11, 32'h0000_3000, 1'b0, 32'd0);

        // Control transfer
        exec(OP_BEQ, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'h100, 4'd1);
        check_res("beq", 4'd1, 32'd0, 1'b1, 32'h0000_00F8);
        exec(OP_BNE, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'h100, 4'd2);
        check_res("bne", 4'd2, 32'd0, 1'b0, 32'h0000_0104);
        exec(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200, 4'd3);
        check_res("blt", 4'd3, 32'd0, 1'b1, 32'h0000_0210);
        exec(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h200, 4'd4);
        check_res("bltu", 4'd4, 32'd0, 1'b0, 32'h0000_0204);
        exec(OP_BGE, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h300, 4'd5);
        check_res("bge", 4'd5, 32'd0, 1'b1, 32'h0000_02F0);
        exec(OP_BGEU, 32'd3, 32'd5, 32'hFFFF_FFF0, 32'h300, 4'd6);
        check_res("bgeu", 4'd6, 32'd0, 1'b0, 32'h0000_0304);
        exec(OP_JAL, 32'd0, 32'd0, 32'h100, 32'h40, 4'd7);
        check_res("jal", 4'd7, 32'h44, 1'b1, 32'h0000_0140);
        exec(OP_JALR, 32'h203, 32'd0, 32'd4, 32'h40, 4'd8);
        check_res("jalr", 4'd8, 32'h44, 1'b1, 32'h0000_0206);

        // Unknown opcode still retires its tag
        exec(6'h3F, 32'd1, 32'd2, 32'd3, 32'h40, 4'd14);
        check_res("unknown", 4'd14, 32'd0, 1'b0, 32'd0);

`ifdef ALU_MUL_EN
        // MULHU at t, ADD at t+1: results on consecutive cycles, no overlap
        drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd12);
        @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd13);
        @(negedge clk);
        bus.flag_alu = 1'b0;
        check_res("mulhu", 4'd12, 32'hFFFF_FFFE, 1'b0, 32'd0);
        @(negedge clk);
        check_res("mul_add", 4'd13, 32'd3, 1'b0, 32'd0);
        @(negedge clk);
        check("mul_add.end", {31'b0, bus.alu_ans_flag}, 32'd0);
        exec(OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 4'd1);
        check_res("mul", 4'd1, 32'hFFFF_FFFD, 1'b0, 32'd0);
        exec(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 4'd2);
        check_res("mulh", 4'd2, 32'h4000_0000, 1'b0, 32'd0);
        exec(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3);
        check_res("mulhsu", 4'd3, 32'hFFFF_FFFF, 1'b0, 32'd0);
`else
        exec(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd12);
        check_res("mulhu_unknown", 4'd12, 32'd0, 1'b0, 32'd0);
`endif

        // Back-to-back issue, tags 1..4 in order on consecutive cycles
        for (int c = 0; c < 4 + LAT + 1; c++) begin
            if (c < 4) drive(OP_ADD, 32'(c), 32'd10, 32'd0, 32'd0, 4'(c + 1));
            else       bus.flag_alu = 1'b0;
            @(negedge clk);
            k = c + 1 - LAT;
            if (k >= 0 && k < 4) begin
                check("b2b.flag",    {31'b0, bus.alu_ans_flag}, 32'd1);
                check("b2b.reorder", 32'(bus.alu_ans_reorder),  32'(k + 1));
                check("b2b.ans",     bus.alu_ans,               32'(k + 10));
            end else begin
                check("b2b.idle", {31'b0, bus.alu_ans_flag}, 32'd0);
            end
        end

        // Freeze: issues while rdy=0 ignored; held result replayed once on resume
        drive(OP_ADD, 32'd20, 32'd22, 32'd0, 32'd0, 4'd5);
        @(negedge clk);
        rdy = 1'b0;
        drive(OP_SUB, 32'd1, 32'd1, 32'd0, 32'd0, 4'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz.flag", {31'b0, bus.alu_ans_flag}, 32'd0);
        end
        bus.flag_alu = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        check_res("frz.replay", 4'd5, 32'd42, 1'b0, 32'd0);
        @(negedge clk);
        check("frz.after", {31'b0, bus.alu_ans_flag}, 32'd0);

        // Issue and clr on the same edge: never produces a result
        clr = 1'b1;
        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd6);
        @(negedge clk);
        check("clr.same_edge", {31'b0, bus.alu_ans_flag}, 32'd0);
        clr = 1'b0;
        bus.flag_alu = 1'b0;
        repeat (LAT + 1) begin
            @(negedge clk);
            check("clr.no_result", {31'b0, bus.alu_ans_flag}, 32'd0);
        end

        // clr during a freeze kills the held op; nothing replays on resume
        drive(OP_ADD, 32'd3, 32'd4, 32'd0, 32'd0, 4'd7);
        @(negedge clk);
        bus.flag_alu = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        check("clr_frz.resume", {31'b0, bus.alu_ans_flag}, 32'd0);
        @(negedge clk);
        check("clr_frz.after",  {31'b0, bus.alu_ans_flag}, 32'd0);

        // Reset mid-operation zeroes outputs and drops the in-flight op
        exec(OP_ADD, 32'd100, 32'd23, 32'd0, 32'd0, 4'd10);
        drive(OP_JAL, 32'd0, 32'd0, 32'h80, 32'h10, 4'd11);
        rst = 1'b1;
        @(negedge clk);
        bus.flag_alu = 1'b0;
        check("rst_mid.flag",    {31'b0, bus.alu_ans_flag}, 32'd0);
        check("rst_mid.reorder", 32'(bus.alu_ans_reorder),  32'd0);
        check("rst_mid.ans",     bus.alu_ans,               32'd0);
        check("rst_mid.jump",    {31'b0, bus.alu_jump},     32'd0);
        check("rst_mid.jump_pc", bus.alu_jump_pc,           32'd0);
        rst = 1'b0;
        repeat (LAT) begin
            @(negedge clk);
            check("rst_mid.after", {31'b0, bus.alu_ans_flag}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
